// File: rtl/posicionador_encouracado.sv
// Placement controller for the 4-cell Encouracado on the 8x8 map.
// ENCOURACADO_OVERLAP_CHECK_EN enables the occupancy check on confirm.
module posicionador_encouracado #(
    parameter logic [3:0] X_INI = 4'd1,
    parameter logic [3:0] Y_INI = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iniciar,
    input  logic        btn_cima,
    input  logic        btn_baixo,
    input  logic        btn_esq,
    input  logic        btn_dir,
    input  logic        btn_girar,
    input  logic        btn_confirma,
    input  logic [63:0] ocupado,
    output logic [63:0] posicoesEmbarcacao,
    output logic        pronto,
    output logic        erro
);

    typedef enum logic [1:0] {IDLE, PLACING, CHECK, DONE} estado_t;

    estado_t    estado;
    logic [3:0] ancX;
    logic [3:0] ancY;
    logic       vertical;
    logic [6:0] btnPrev;

    logic [6:0] btns;
    logic [6:0] ev;
    logic [6:0] acao;
    logic [3:0] cx [4];
    logic [3:0] cy [4];
    logic [3:0] nxtX;
    logic [3:0] nxtY;
    logic       movLegal;
    logic       girLegal;
    logic [63:0] vetor;

    // bit 0 has the highest priority; acao keeps only the lowest set event
    assign btns = {btn_dir, btn_esq, btn_baixo, btn_cima,
                   btn_girar, btn_confirma, iniciar};
    assign ev   = btns & ~btnPrev;
    assign acao = ev & (~ev + 7'd1);

    function automatic logic legal(input logic [3:0] x,
                                   input logic [3:0] y,
                                   input logic       v);
        if (v)
            return (x >= 4'd1) && (x <= 4'd8) && (y >= 4'd1) && (y <= 4'd5);
        else
            return (x >= 4'd1) && (x <= 4'd5) && (y >= 4'd1) && (y <= 4'd8);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cx[i] = vertical ? ancX : ancX + 4'(i);
            cy[i] = vertical ? ancY + 4'(i) : ancY;
        end
    end

    always_comb begin
        nxtX = ancX;
        nxtY = ancY;
        unique case (1'b1)
            acao[3]: nxtY = ancY + 4'd1;
            acao[4]: nxtY = ancY - 4'd1;
            acao[5]: nxtX = ancX - 4'd1;
            acao[6]: nxtX = ancX + 4'd1;
            default: ;
        endcase
    end

    assign movLegal = legal(nxtX, nxtY, vertical);
    assign girLegal = legal(ancX, ancY, ~vertical);

    always_comb begin
        vetor = '0;
        if (estado != IDLE) begin
            vetor[0] = (estado == PLACING) || (estado == CHECK);
            vetor[1] = vertical;
            vetor[2] = (estado == DONE);
            for (int i = 0; i < 4; i++) begin
                vetor[3 + 8*i +: 4] = cx[i];
                vetor[7 + 8*i +: 4] = cy[i];
            end
        end
    end

`ifdef ENCOURACADO_OVERLAP_CHECK_EN
    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < 4; i++)
            hit = hit | ocupado[{cy[i][2:0] - 3'd1, cx[i][2:0] - 3'd1}];
    end
`else
    logic unusedOcupado;

    assign unusedOcupado = ^ocupado;
    assign erro          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado             <= IDLE;
            ancX               <= X_INI;
            ancY               <= Y_INI;
            vertical           <= 1'b0;
            btnPrev            <= '0;
            posicoesEmbarcacao <= '0;
            pronto             <= 1'b0;
`ifdef ENCOURACADO_OVERLAP_CHECK_EN
            erro               <= 1'b0;
`endif
        end else begin
            btnPrev            <= btns;
            posicoesEmbarcacao <= vetor;
            pronto             <= 1'b0;
`ifdef ENCOURACADO_OVERLAP_CHECK_EN
            erro               <= 1'b0;
`endif
            case (estado)
                IDLE: begin
                    if (acao[0]) begin
                        ancX     <= X_INI;
                        ancY     <= Y_INI;
                        vertical <= 1'b0;
                        estado   <= PLACING;
                    end
                end
                PLACING: begin
                    unique case (1'b1)
                        acao[0]: begin
                            ancX     <= X_INI;
                            ancY     <= Y_INI;
                            vertical <= 1'b0;
                        end
                        acao[1]: estado <= CHECK;
                        acao[2]: begin
                            if (girLegal)
                                vertical <= ~vertical;
                        end
                        acao[3], acao[4], acao[5], acao[6]: begin
                            if (movLegal) begin
                                ancX <= nxtX;
                                ancY <= nxtY;
                            end
                        end
                        default: ;
                    endcase
                end
                CHECK: begin
`ifdef ENCOURACADO_OVERLAP_CHECK_EN
                    if (hit) begin
                        erro   <= 1'b1;
                        estado <= PLACING;
                    end else
`endif
                    begin
                        pronto <= 1'b1;
                        estado <= DONE;
                    end
                end
                DONE: begin
                    if (acao[0]) begin
                        ancX     <= X_INI;
                        ancY     <= Y_INI;
                        vertical <= 1'b0;
                        estado   <= PLACING;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/posicionador_encouracado.md
# posicionador_encouracado

- Interactive placement controller for the 4-cell Encouracado (battleship) on the 8x8 map.
- Takes debounced player buttons, moves and rotates a ship anchor inside the board, and rejects moves that leave the board.
- On confirmation it checks the ship against an occupancy map.
- Produces the packed `posicoesEmbarcacao` vector consumed by the VGA ship renderer. It is the writer side of that interface.

## Interface
Parameters:
- `X_INI`, default 1: anchor X code loaded on start (1..5).
- `Y_INI`, default 1: anchor Y code loaded on start (1..8).

Ports:
- `clk`  in  1: system clock; everything is synchronous to its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `iniciar`  in  1: level; its rising edge starts or restarts placement.
- `btn_cima`, `btn_baixo`, `btn_esq`, `btn_dir`  in  1 each: debounced levels.
  - `btn_cima` / `btn_baixo`: Y code +1 / -1.
  - `btn_esq` / `btn_dir`: X code -1 / +1.
- `btn_girar`  in  1: debounced level; toggles orientation.
- `btn_confirma`  in  1: debounced level; requests commit.
- `ocupado`  in  64: occupancy map; bit `(y-1)*8+(x-1)` is set when cell (x,y) is already taken.
- `posicoesEmbarcacao`  out  64: registered packed cell vector.
- `pronto`  out  1: one-cycle pulse when placement is committed.
- `erro`  out  1: one-cycle pulse when a confirm is rejected.

## Operation
Packing of `posicoesEmbarcacao`:
- [2:0] = {confirmado, vertical, ativo}.
- [6:3] XA, [10:7] YA.
- [14:11] XB, [18:15] YB.
- [22:19] XC, [26:23] YC.
- [30:27] XD, [34:31] YD.
- [63:35] are always 0.
- Coordinate codes are 1..8. A larger Y code is higher on screen.

Cells:
- Horizontal: A=(x,y), B=(x+1,y), C=(x+2,y), D=(x+3,y).
- Vertical: A=(x,y), B=(x,y+1), C=(x,y+2), D=(x,y+3).
- Legal anchors: horizontal requires x in 1..5 and y in 1..8; vertical requires x in 1..8 and y in 1..5.

Edge detection:
- Each button and `iniciar` has a previous-sample register.
- An event is sampled high while its previous sample is low.
- At most one action is taken per cycle. Priority: iniciar > confirma > girar > cima > baixo > esq > dir. Lower-priority edges in the same cycle are discarded.

FSM:
- **IDLE**: `iniciar` event → load anchor (`X_INI`, `Y_INI`), horizontal → PLACING.
- **PLACING**:
  - Move event: the new anchor is applied only if it is legal; otherwise the anchor is unchanged and nothing else happens.
  - `girar` event: toggles orientation only if the current anchor is legal in the new orientation.
  - `confirma` event → CHECK.
  - `iniciar` event: reload the start anchor and horizontal orientation, stay in PLACING.
- **CHECK** (exactly one cycle): if any of the four cells hits a set bit in `ocupado` → `erro` pulse, return to PLACING. Otherwise → `pronto` pulse, go to DONE. Buttons are ignored in CHECK.
- **DONE**: anchor is frozen and the vector holds with confirmado=1. An `iniciar` event → PLACING with the start anchor.

Status bits:
- ativo = 1 in PLACING and CHECK.
- vertical = current orientation.
- In IDLE the whole vector is 0.

Arithmetic: anchor counters are 4-bit. Cell codes are computed on a 4-bit add and never exceed 8, because only legal anchors are stored.

## Timing
Reset: state IDLE, anchor reset to the start values, orientation horizontal, all edge registers 0, `posicoesEmbarcacao`=0, `pronto`=0, `erro`=0.

Latency:
- Input sampled high at edge k with its previous sample low → state/anchor update at edge k.
- `posicoesEmbarcacao` reflects that update at edge k+1.
- `pronto` / `erro` are asserted for the single cycle after CHECK's edge.

Other timing rules:
- A held button produces one event only. It must drop for at least one cycle before it can produce another.
- `ocupado` is sampled on the CHECK cycle only; it must be stable then.
- Asserting `rst_n` low mid-placement or during CHECK clears everything immediately, with no `pronto`/`erro` pulse.

## Configuration
- `ENCOURACADO_OVERLAP_CHECK_EN` defined: CHECK compares the four cells against `ocupado` as described above.
- Macro undefined: `ocupado` is ignored, CHECK always commits, and `erro` is tied to 0. CHECK's one-cycle latency is retained.

## Test plan
- Reset, then an `iniciar` edge with default parameters → two cycles later `posicoesEmbarcacao` = 64'h00000000_A0989089 (cells (1,1)..(4,1), ativo=1).
- From anchor (5,1) horizontal, `btn_dir` edge → vector unchanged. Then `btn_girar` edge → vertical, cells (5,1)(5,2)(5,3)(5,4), bit1=1.
- From anchor (1,5) vertical, `btn_cima` held for 10 cycles → exactly one attempted move, rejected; anchor remains (1,5).
- `btn_girar` and `btn_cima` rising in the same cycle at (1,1) horizontal → only the rotation occurs; the vector shows vertical at (1,1).
- Macro on, `ocupado` bit 2 set (cell (3,1)), confirm at (1,1) horizontal → `erro`=1 for one cycle and state returns to PLACING. Then `btn_cima` and confirm → `pronto` pulse, bit2=1, and further moves are ignored.
- Reset asserted during CHECK → next edge shows vector 0, `pronto`=`erro`=0, state IDLE. Macro off with `ocupado`=all ones → confirm yields `pronto`.
